matmul_mxn_stream: RTL and testbench
====================================

Name: matmul_mxn_stream

Overview:
Parametrised successor to the fixed 2x2 matrix-multiply engine. Computes C[MxN] = A[MxK] * B[KxN] using an MxN array of signed multiply-accumulate cells. Operands stream in one k-slice per beat (column of A, row of B) over a valid/ready handshake. The runtime depth k_len can be up to K_MAX. Results are held under a valid/ready output handshake, with optional saturation. Sits between the AXI operand buffers and the result writeback path.

Parameters:
DATA_W, 8, signed operand element width
ACC_W, 32, signed accumulator/result width (must be >= 2*DATA_W)
M, 2, rows of A and C
N, 2, columns of B and C
K_MAX, 16, maximum supported inner dimension
SAT, 0, 1 = saturate accumulators to the signed ACC_W range; 0 = two's-complement wrap
KW, $clog2(K_MAX+1), width of k_len (derived; not for override)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  job start pulse; sampled only in IDLE
k_len  in  KW  inner dimension for the job; latched on accepted start; values > K_MAX are clamped to K_MAX
in_valid  in  1  operand beat valid
in_ready  out  1  operand beat accepted when in_valid && in_ready
a_col  in  M*DATA_W  A[i][k]; element i at [i*DATA_W +: DATA_W]
b_row  in  N*DATA_W  B[k][j]; element j at [j*DATA_W +: DATA_W]
c_valid  out  1  result valid
c_ready  in  1  result consumed when c_valid && c_ready
c_flat  out  M*N*ACC_W  C[i][j] at [(i*N+j)*ACC_W +: ACC_W]
busy  out  1  high whenever state != IDLE
overflow  out  1  sticky per job; set if any accumulate exceeded the signed ACC_W range

Behaviour:
- One clock: clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=0, c_valid=0, busy=0, overflow=0, all accumulators and c_flat=0, beat counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start, when latched k_len != 0. On the same edge: clear accumulators, clear overflow, reset beat counter.
- IDLE -> DONE on start, when k_len == 0. Accumulators are cleared, so the result is all zeros with c_valid=1 the next cycle.
- RUN:
  - in_ready=1.
  - Each accepted beat: acc[i][j] <= acc[i][j] + sext(a_col[i]*b_row[j]) for all i,j in parallel. The product is a full 2*DATA_W signed value, sign-extended to ACC_W+1 for the add.
  - Beat counter increments per accepted beat. Cycles with in_valid=0 leave all state unchanged.
- Accept of beat number k_len-1 -> DONE.
  - c_valid rises the cycle after the final accepted beat (latency 1 from last beat).
  - c_flat reflects the accumulators including the final beat.
- DONE:
  - in_ready=0; c_valid=1; c_flat and overflow held stable until c_valid && c_ready.
  - On that handshake -> IDLE; c_valid drops the next cycle.
  - c_flat keeps its last value in IDLE. overflow holds until the next accepted start.
- start outside IDLE is ignored; no queueing.
- Arithmetic, per cell, per beat, using the ACC_W+1-bit sum:
  - SAT=1: sum above +2^(ACC_W-1)-1 clamps to max; sum below -2^(ACC_W-1) clamps to min. Either case sets overflow.
  - SAT=0: wrap to ACC_W bits and still set overflow on range exceedance.
- Accumulators change only on an accepted beat or on a start-clear. c_flat never changes while c_valid=1.
- rst mid-RUN or mid-DONE: return to IDLE immediately with reset values. Partial sums are discarded.
- Simulation-only assertions (`ifndef SYNTHESIS):
  - in_ready && c_valid never both high.
  - c_flat stable while c_valid && !c_ready.
  - Beat counter < k_len in RUN.
  - busy == (state != IDLE).

Test Plan:
1. M=N=2, K_MAX=16, k_len=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], beats back-to-back -> c_valid one cycle after beat 2; C=[[19,22],[43,50]]; overflow=0.
2. Same job with in_valid low for 3 cycles between beats and c_ready held low for 5 cycles -> identical C. c_flat stable and c_valid high throughout the stall. Exactly 2 beats accepted.
3. start with k_len=0 -> c_valid the next cycle, C all zeros. k_len=20 -> clamped; exactly 16 beats accepted before c_valid.
4. DATA_W=8, ACC_W=16, SAT=1, k_len=4, all operands -128 (product 16384) -> every C element 32767, overflow=1. Same run with SAT=0 -> wrapped value 0 (65536 mod 2^16), overflow=1.
5. rst pulsed after 1 of 3 beats -> outputs return to reset values next cycle. A fresh k_len=1 job with a=[2,3], b=[4,5] gives C=[[8,10],[12,15]], unpolluted by the aborted job.
6. start pulses asserted during RUN and DONE -> ignored; busy stays high. Only one c_valid handshake occurs per accepted start.

Source files
------------

// File: rtl/matmul_mxn_stream.sv
// Streaming MxN signed matrix-multiply engine.
// C[MxN] = A[MxK] * B[KxN], one k-slice (column of A, row of B) per accepted beat.
// Results are held under a valid/ready handshake; optional saturation.
module matmul_mxn_stream #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int M      = 2,
  parameter int N      = 2,
  parameter int K_MAX  = 16,
  parameter int SAT    = 0,
  parameter int KW     = $clog2(K_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [M*DATA_W-1:0]   a_col,
  input  logic [N*DATA_W-1:0]   b_row,
  output logic                  c_valid,
  input  logic                  c_ready,
  output logic [M*N*ACC_W-1:0]  c_flat,
  output logic                  busy,
  output logic                  overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CELLS = M * N;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    klen_q, klen_d;
  logic [KW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q [CELLS];
  logic [ACC_W-1:0] acc_d [CELLS];
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] step_val [CELLS];
  logic [CELLS-1:0] cell_ovf;
  logic [KW-1:0]    klen_clamped;

  // Per-cell multiply-accumulate step using an ACC_W+1-bit sum so range exceedance is visible.
  for (genvar gi = 0; gi < M; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      localparam int C = gi * N + gj;
      logic [DATA_W-1:0]   a_e, b_e;
      logic [2*DATA_W-1:0] prod;
      logic [ACC_W:0]      sum;

      assign a_e  = a_col[gi*DATA_W +: DATA_W];
      assign b_e  = b_row[gj*DATA_W +: DATA_W];
      // Sign-extend both operands to the product width; the low 2*DATA_W bits are the signed product.
      assign prod = {{DATA_W{a_e[DATA_W-1]}}, a_e} * {{DATA_W{b_e[DATA_W-1]}}, b_e};
      assign sum  = {acc_q[C][ACC_W-1], acc_q[C]}
                  + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      assign cell_ovf[C] = sum[ACC_W] ^ sum[ACC_W-1];
      assign step_val[C] = ((SAT != 0) && cell_ovf[C]) ? (sum[ACC_W] ? ACC_MIN : ACC_MAX)
                                                       : sum[ACC_W-1:0];
      assign c_flat[C*ACC_W +: ACC_W] = acc_q[C];
    end
  end

  assign klen_clamped = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;

  assign in_ready = (state_q == RUN);
  assign c_valid  = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;

  // Next-state logic: job start, beat accumulation, result handshake.
  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          klen_d  = klen_clamped;
          cnt_d   = '0;
          acc_d   = '{default: '0};
          ovf_d   = 1'b0;
          state_d = (klen_clamped == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          acc_d = step_val;
          ovf_d = ovf_q | (|cell_ovf);
          cnt_d = cnt_q + KW'(1);
          if (cnt_q == klen_q - KW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (c_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      klen_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '{default: '0};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

`ifndef SYNTHESIS
  a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(in_ready && c_valid));
  a_hold:       assert property (@(posedge clk) disable iff (rst)
                                 (c_valid && !c_ready) |=> $stable(c_flat));
  a_cnt:        assert property (@(posedge clk) disable iff (rst)
                                 (state_q == RUN) |-> (cnt_q < klen_q));
  a_busy:       assert property (@(posedge clk) busy == (state_q != IDLE));
`endif

endmodule

// File: tb/tb_matmul_mxn_stream.sv
// Self-checking bench for matmul_mxn_stream: vector table plus hand-written corner sequences,
// with a scoreboard queue of expected results popped at each result handshake.
module tb_matmul_mxn_stream;

  localparam int DW = 8;
  localparam int M  = 2;
  localparam int N  = 2;
  localparam int KM = 16;
  localparam int KW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, in_valid, c_ready;
  logic [KW-1:0] k_len;
  logic [15:0]   a_col, b_row;

  logic          in_ready, c_valid, busy, overflow;
  logic [127:0]  c_flat;
  logic          s_in_ready, s_c_valid, s_busy, s_overflow;
  logic [63:0]   s_c_flat;
  logic          w_in_ready, w_c_valid, w_busy, w_overflow;
  logic [63:0]   w_c_flat;

  matmul_mxn_stream #(.DATA_W(DW), .ACC_W(32), .M(M), .N(N), .K_MAX(KM), .SAT(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid), .in_ready(in_ready),
    .a_col(a_col), .b_row(b_row), .c_valid(c_valid), .c_ready(c_ready), .c_flat(c_flat),
    .busy(busy), .overflow(overflow));

  matmul_mxn_stream #(.DATA_W(DW), .ACC_W(16), .M(M), .N(N), .K_MAX(KM), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid), .in_ready(s_in_ready),
    .a_col(a_col), .b_row(b_row), .c_valid(s_c_valid), .c_ready(c_ready), .c_flat(s_c_flat),
    .busy(s_busy), .overflow(s_overflow));

  matmul_mxn_stream #(.DATA_W(DW), .ACC_W(16), .M(M), .N(N), .K_MAX(KM), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid), .in_ready(w_in_ready),
    .a_col(a_col), .b_row(b_row), .c_valid(w_c_valid), .c_ready(c_ready), .c_flat(w_c_flat),
    .busy(w_busy), .overflow(w_overflow));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [127:0] c;
    logic         ovf;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int           k;
    int           gap;
    int           stall;
    logic [15:0]  a[3];
    logic [15:0]  b[3];
    logic [127:0] c;
    logic         ovf;
  } vec_t;
  vec_t vecs[5];

  logic [15:0] ba[20];
  logic [15:0] bb[20];
  bit          noise_start = 1'b0;
  bit          chk16 = 1'b0;

  int beats_total = 0;
  int hs_total = 0;
  always @(posedge clk) begin
    if (in_valid && in_ready) beats_total++;
    if (c_valid && c_ready) hs_total++;
  end

  task automatic checkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model for the 32-bit wrapping instance.
  function automatic exp_t model(input int k);
    exp_t e;
    int eff;
    longint s;
    logic signed [7:0] x, y;
    e.c = '0;
    e.ovf = 1'b0;
    eff = (k > KM) ? KM : k;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int t = 0; t < eff; t++) begin
          x = ba[t][i*8 +: 8];
          y = bb[t][j*8 +: 8];
          s = s + longint'(x) * longint'(y);
          if (s > 64'sd2147483647 || s < -64'sd2147483648) begin
            e.ovf = 1'b1;
            s = longint'($signed(s[31:0]));
          end
        end
        e.c[(i*N+j)*32 +: 32] = s[31:0];
      end
    end
    return e;
  endfunction

  task automatic run_job(input int k, input int gap, input int stall, input string tag);
    int eff, b0, h0, waitc;
    logic [127:0] snap;
    exp_t e;
    eff = (k > KM) ? KM : k;
    b0 = beats_total;
    h0 = hs_total;
    k_len = k[KW-1:0];
    start = 1'b1;
    tick;
    start = noise_start;
    check1($sformatf("%s busy_after_start", tag), busy, 1'b1);
    for (int t = 0; t < eff; t++) begin
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) tick;
      end
      a_col = ba[t];
      b_row = bb[t];
      in_valid = 1'b1;
      waitc = 0;
      while (!in_ready && waitc < 50) begin
        tick;
        waitc++;
      end
      if (!in_ready) begin
        check1($sformatf("%s in_ready_timeout", tag), in_ready, 1'b1);
        break;
      end
      tick;
    end
    // Keep presenting junk beats after the last accept; they must be ignored.
    a_col = 16'h7f7f;
    b_row = 16'h7f7f;
    in_valid = 1'b1;
    check1($sformatf("%s c_valid_latency", tag), c_valid, 1'b1);
    check1($sformatf("%s in_ready_done", tag), in_ready, 1'b0);
    checki($sformatf("%s beats_accepted", tag), beats_total - b0, eff);
    snap = c_flat;
    c_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      tick;
      check1($sformatf("%s stall_c_valid", tag), c_valid, 1'b1);
      check1($sformatf("%s stall_busy", tag), busy, 1'b1);
      checkw($sformatf("%s stall_c_flat", tag), c_flat, snap);
    end
    if (chk16) begin
      checkw($sformatf("%s sat_c_flat", tag), {64'h0, s_c_flat}, {64'h0, {4{16'h7FFF}}});
      check1($sformatf("%s sat_overflow", tag), s_overflow, 1'b1);
      checkw($sformatf("%s wrap_c_flat", tag), {64'h0, w_c_flat}, 128'h0);
      check1($sformatf("%s wrap_overflow", tag), w_overflow, 1'b1);
    end
    if (exp_q.size() == 0) begin
      checki($sformatf("%s scoreboard_empty", tag), 0, 1);
    end else begin
      e = exp_q.pop_front();
      checkw($sformatf("%s c_flat", tag), c_flat, e.c);
      check1($sformatf("%s overflow", tag), overflow, e.ovf);
    end
    c_ready = 1'b1;
    tick;
    c_ready = 1'b0;
    in_valid = 1'b0;
    start = 1'b0;
    check1($sformatf("%s c_valid_drop", tag), c_valid, 1'b0);
    check1($sformatf("%s busy_idle", tag), busy, 1'b0);
    checki($sformatf("%s handshakes", tag), hs_total - h0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [127:0] held;

    vecs[0] = '{k: 2, gap: 0, stall: 0, a: '{16'h0301, 16'h0402, 16'h0}, b: '{16'h0605, 16'h0807, 16'h0},
                c: 128'h00000032_0000002b_00000016_00000013, ovf: 1'b0};
    vecs[1] = '{k: 2, gap: 3, stall: 5, a: '{16'h0301, 16'h0402, 16'h0}, b: '{16'h0605, 16'h0807, 16'h0},
                c: 128'h00000032_0000002b_00000016_00000013, ovf: 1'b0};
    vecs[2] = '{k: 1, gap: 0, stall: 1, a: '{16'h02FF, 16'h0, 16'h0}, b: '{16'hFC03, 16'h0, 16'h0},
                c: 128'hFFFFFFF8_00000006_00000004_FFFFFFFD, ovf: 1'b0};
    vecs[3] = '{k: 3, gap: 1, stall: 1, a: '{16'h8080, 16'h8080, 16'h8080}, b: '{16'h8080, 16'h8080, 16'h8080},
                c: {4{32'h0000C000}}, ovf: 1'b0};
    vecs[4] = '{k: 0, gap: 0, stall: 2, a: '{16'h0, 16'h0, 16'h0}, b: '{16'h0, 16'h0, 16'h0},
                c: 128'h0, ovf: 1'b0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; c_ready = 1'b0;
    k_len = '0; a_col = '0; b_row = '0;
    repeat (3) tick;
    rst = 1'b0;
    check1("reset in_ready", in_ready, 1'b0);
    check1("reset c_valid", c_valid, 1'b0);
    check1("reset busy", busy, 1'b0);
    check1("reset overflow", overflow, 1'b0);
    checkw("reset c_flat", c_flat, 128'h0);

    // Table-driven jobs.
    for (int v = 0; v < 5; v++) begin
      for (int t = 0; t < 20; t++) begin
        ba[t] = (t < 3) ? vecs[v].a[t] : 16'h0;
        bb[t] = (t < 3) ? vecs[v].b[t] : 16'h0;
      end
      e.c = vecs[v].c;
      e.ovf = vecs[v].ovf;
      exp_q.push_back(e);
      run_job(vecs[v].k, vecs[v].gap, vecs[v].stall, $sformatf("vec%0d", v));
    end

    // k_len above K_MAX is clamped: exactly 16 beats are taken.
    for (int t = 0; t < 20; t++) begin
      ba[t] = 16'($urandom);
      bb[t] = 16'($urandom);
    end
    exp_q.push_back(model(20));
    run_job(20, 0, 1, "clamp");

    // Random job with gaps, checked against the model.
    for (int t = 0; t < 20; t++) begin
      ba[t] = 16'($urandom);
      bb[t] = 16'($urandom);
    end
    exp_q.push_back(model(7));
    run_job(7, 1, 2, "rand7");

    // Saturating and wrapping 16-bit instances on -128 * -128, four beats.
    for (int t = 0; t < 20; t++) begin
      ba[t] = 16'h8080;
      bb[t] = 16'h8080;
    end
    exp_q.push_back(model(4));
    chk16 = 1'b1;
    run_job(4, 0, 2, "sat16");
    chk16 = 1'b0;
    held = c_flat;
    tick;
    check1("idle sat overflow_held", s_overflow, 1'b1);
    checkw("idle c_flat_held", c_flat, held);

    // Reset in the middle of a job discards the partial sums.
    k_len = 5'd3;
    start = 1'b1;
    tick;
    start = 1'b0;
    a_col = 16'h0301;
    b_row = 16'h0605;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check1("abort busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check1("abort in_ready", in_ready, 1'b0);
    check1("abort c_valid", c_valid, 1'b0);
    check1("abort busy", busy, 1'b0);
    check1("abort overflow", overflow, 1'b0);
    checkw("abort c_flat", c_flat, 128'h0);
    ba[0] = 16'h0302;
    bb[0] = 16'h0504;
    e.c = 128'h0000000F_0000000C_0000000A_00000008;
    e.ovf = 1'b0;
    exp_q.push_back(e);
    run_job(1, 0, 0, "fresh");

    // start held high through RUN and DONE must be ignored.
    ba[0] = 16'h0301; ba[1] = 16'h0402;
    bb[0] = 16'h0605; bb[1] = 16'h0807;
    e.c = 128'h00000032_0000002b_00000016_00000013;
    e.ovf = 1'b0;
    exp_q.push_back(e);
    noise_start = 1'b1;
    run_job(2, 1, 2, "noise");
    noise_start = 1'b0;
    tick;
    check1("noise stays_idle", busy, 1'b0);

    checki("scoreboard drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
